// File: rtl/shr_stim_seq.sv
// Stimulus sequencer and response compactor for the BRAM shift-register harness.
// Optional feature macro: SHR_STIM_MISR_EN (defined = 16-bit MISR, undefined = last-8-bit capture).
module shr_stim_seq #(
   parameter int          DIN_N  = 8,
   parameter int          DOUT_N = 8,
   parameter int          NVEC   = 16,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        dut_do,
   output logic        di,
   output logic        stb,
   output logic        busy,
   output logic        done,
   output logic [15:0] vec_cnt,
   output logic [15:0] signature
);

   typedef enum logic [2:0] {IDLE, SHIFT, STROBE, CAPTURE, DONE} state_t;

   localparam int              CNT_MAX    = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
   localparam int              CNT_W      = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DIN_N - 1);
   localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DOUT_N - 1);
   localparam logic [15:0]      NVEC_W     = 16'(NVEC);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [15:0]        vec_cnt_q, vec_cnt_d;
   logic [15:0]        sig_q, sig_d;
   logic               di_q, di_d;
   logic               stb_q, stb_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Fibonacci x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Vectors wider than the LFSR are zero-extended above bit 15.
   function automatic logic vec_bit(input logic [15:0] s, input int idx);
      if (idx < 16) return s[idx[3:0]];
      return 1'b0;
   endfunction

   function automatic logic [15:0] sig_step(input logic [15:0] s, input logic b);
`ifdef SHR_STIM_MISR_EN
      return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
`else
      return {s[14:0], b} & 16'h00FF;
`endif
   endfunction

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      lfsr_d    = lfsr_q;
      vec_cnt_d = vec_cnt_q;
      sig_d     = sig_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               lfsr_d    = SEED;
               vec_cnt_d = '0;
               sig_d     = '0;
            end
         end
         SHIFT: begin
            if (bit_cnt_q == SHIFT_LAST) begin
               state_d   = STROBE;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         STROBE: begin
            lfsr_d    = lfsr_step(lfsr_q);
            bit_cnt_d = '0;
            state_d   = CAPTURE;
         end
         CAPTURE: begin
            sig_d = sig_step(sig_q, dut_do);
            if (bit_cnt_q == CAP_LAST) begin
               bit_cnt_d = '0;
               vec_cnt_d = vec_cnt_q + 16'd1;
               state_d   = (vec_cnt_q + 16'd1 == NVEC_W) ? DONE : SHIFT;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies line up with state_q.
      di_d   = (state_d == SHIFT) ? vec_bit(lfsr_d, DIN_N - 1 - int'(bit_cnt_d)) : 1'b0;
      stb_d  = (state_d == STROBE);
      busy_d = (state_d == SHIFT) || (state_d == STROBE) || (state_d == CAPTURE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         lfsr_q    <= SEED;
         vec_cnt_q <= '0;
         sig_q     <= '0;
         di_q      <= 1'b0;
         stb_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         lfsr_q    <= lfsr_d;
         vec_cnt_q <= vec_cnt_d;
         sig_q     <= sig_d;
         di_q      <= di_d;
         stb_q     <= stb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign di        = di_q;
   assign stb       = stb_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign vec_cnt   = vec_cnt_q;
   assign signature = sig_q;

endmodule
